pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves three events: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses with a req/ready handshake. It also keeps a sticky memory-timeout error and a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 10 +
 rtl/pipe_hazard_ctrl_if.sv | 29 ++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 14 +
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Combinational definitions only; no latency or backpressure of its own.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int WAIT_W = 8;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs, stage enable/flush controls and data-memory req/ready between controller and datapath.
// Pure wiring; dmem_req is held until dmem_ready completes the access.
interface pipe_hazard_ctrl_if;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic [1:0] exmem_m;
  logic       branch_taken;
  logic       dmem_ready;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_en;
  logic       memwb_flush;
  logic       dmem_req;

  modport master (
    input  ifid_rs, ifid_rt, idex_memread, idex_rt, exmem_m, branch_taken, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, dmem_req
  );

  modport slave (
    output ifid_rs, ifid_rt, idex_memread, idex_rt, exmem_m, branch_taken, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, dmem_req
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use detector: ID/EX load targets a source register of the IF/ID instruction.
// Zero latency, purely combinational; no backpressure.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  output logic       load_use
);
  assign load_use = idex_memread && (idex_rt != REG_ZERO) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, multi-cycle dmem waits.
// Controls are combinational from state/inputs; a pending dmem access freezes PC..EX/MEM until dmem_ready.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_hazard_ctrl_if.master   bus,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_count
);
  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              timeout_nxt;
  logic              load_use;
  logic              mem_access;

  load_use_detect u_load_use (
    .ifid_rs      (bus.ifid_rs),
    .ifid_rt      (bus.ifid_rt),
    .idex_memread (bus.idex_memread),
    .idex_rt      (bus.idex_rt),
    .load_use     (load_use)
  );

  assign mem_access = bus.exmem_m[M_MEMREAD] | bus.exmem_m[M_MEMWRITE];

  always_comb begin
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_en     = 1'b1;
    bus.idex_flush  = 1'b0;
    bus.exmem_en    = 1'b1;
    bus.memwb_flush = 1'b0;
    bus.dmem_req    = 1'b0;
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    timeout_nxt     = mem_timeout;

    case (state)
      RUN: begin
        bus.dmem_req = mem_access;
        if (mem_access && !bus.dmem_ready) begin
          bus.pc_en       = 1'b0;
          bus.ifid_en     = 1'b0;
          bus.idex_en     = 1'b0;
          bus.exmem_en    = 1'b0;
          bus.memwb_flush = 1'b1;
          state_nxt       = MEM_WAIT;
          wait_cnt_nxt    = '0;
        end else if (bus.branch_taken) begin
          bus.ifid_flush = 1'b1;
          bus.idex_flush = 1'b1;
        end else if (load_use) begin
          bus.pc_en      = 1'b0;
          bus.ifid_en    = 1'b0;
          bus.idex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        bus.dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          state_nxt = RUN;
        end else begin
          bus.pc_en       = 1'b0;
          bus.ifid_en     = 1'b0;
          bus.idex_en     = 1'b0;
          bus.exmem_en    = 1'b0;
          bus.memwb_flush = 1'b1;
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_nxt   = ERROR;
            timeout_nxt = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
      end
      ERROR: begin
        bus.pc_en    = 1'b0;
        bus.ifid_en  = 1'b0;
        bus.idex_en  = 1'b0;
        bus.exmem_en = 1'b0;
      end
      default: state_nxt = RUN;
    endcase

    // Reset wins over everything, including an outstanding dmem request.
    if (!rst) begin
      bus.pc_en       = 1'b0;
      bus.ifid_en     = 1'b0;
      bus.ifid_flush  = 1'b0;
      bus.idex_en     = 1'b0;
      bus.idex_flush  = 1'b0;
      bus.exmem_en    = 1'b0;
      bus.memwb_flush = 1'b0;
      bus.dmem_req    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (!bus.pc_en && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4) with hand-computed control vectors.
module tb_pipe_hazard_ctrl;
  // Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush, dmem_req}
  localparam logic [31:0] C_IDLE   = 32'b1101_0100;
  localparam logic [31:0] C_FROZEN = 32'b0000_0011;
  localparam logic [31:0] C_MEMREL = 32'b1101_0101;
  localparam logic [31:0] C_OFF    = 32'b0000_0000;
  localparam logic [31:0] C_LU     = 32'b0001_1100;
  localparam logic [31:0] C_BR     = 32'b1111_1100;
  localparam logic [31:0] C_BR_MEM = 32'b1111_1101;

  logic       clk;
  logic       rst;
  logic       mem_timeout;
  logic [3:0] stall_count;
  int         n_chk;
  int         n_pass;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_timeout (mem_timeout),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ctl();
    return 32'({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                bus.idex_flush, bus.exmem_en, bus.memwb_flush, bus.dmem_req});
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.ifid_rs      = 5'd0;
    bus.ifid_rt      = 5'd0;
    bus.idex_memread = 1'b0;
    bus.idex_rt      = 5'd0;
    bus.exmem_m      = 2'b00;
    bus.branch_taken = 1'b0;
    bus.dmem_ready   = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    idle_inputs();
    step();
    step();

    // Reset while parked in MEM_WAIT
    rst = 1'b1;
    bus.exmem_m = 2'b10;
    step();
    settle(); check("mw_before_rst", ctl(), C_FROZEN);
    rst = 1'b0;
    settle(); check("rst_outputs_off", ctl(), C_OFF);
    step();
    step();
    rst = 1'b1;
    bus.exmem_m = 2'b00;
    settle(); check("rst_run_ctl", ctl(), C_IDLE);
    check("rst_stall_cnt", 32'(stall_count), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);

    // Load-use on rs
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
    settle(); check("lu_rs_ctl", ctl(), C_LU);
    step();
    check("lu_rs_cnt", 32'(stall_count), 32'd1);
    bus.idex_memread = 1'b0;
    settle(); check("lu_after_bubble", ctl(), C_IDLE);
    // rt == $zero never stalls
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
    settle(); check("lu_zero_ctl", ctl(), C_IDLE);
    step();
    check("lu_zero_cnt", 32'(stall_count), 32'd1);
    // Match on rt field
    bus.idex_rt = 5'd9; bus.ifid_rs = 5'd3; bus.ifid_rt = 5'd9;
    settle(); check("lu_rt_ctl", ctl(), C_LU);
    step();
    check("lu_rt_cnt", 32'(stall_count), 32'd2);
    bus.ifid_rt = 5'd4;
    settle(); check("lu_nomatch_ctl", ctl(), C_IDLE);

    // Branch overrides load-use
    bus.ifid_rt = 5'd9; bus.branch_taken = 1'b1;
    settle(); check("br_lu_ctl", ctl(), C_BR);
    step();
    check("br_lu_cnt", 32'(stall_count), 32'd2);
    // Single-cycle memory access alongside a branch
    bus.exmem_m = 2'b01; bus.dmem_ready = 1'b1;
    settle(); check("br_mem_ctl", ctl(), C_BR_MEM);
    step();
    idle_inputs();

    // Memory wait: three frozen cycles then release
    reset_pulse();
    bus.exmem_m = 2'b10;
    for (int i = 0; i < 3; i++) begin
      settle(); check($sformatf("mw_frozen_%0d", i), ctl(), C_FROZEN);
      step();
    end
    bus.dmem_ready = 1'b1;
    settle(); check("mw_release_ctl", ctl(), C_MEMREL);
    step();
    check("mw_stall_cnt", 32'(stall_count), 32'd3);
    idle_inputs();
    settle(); check("mw_back_run", ctl(), C_IDLE);

    // Timeout: one RUN cycle plus four MEM_WAIT cycles, then ERROR
    reset_pulse();
    bus.exmem_m = 2'b01;
    for (int i = 0; i < 5; i++) begin
      settle(); check($sformatf("to_frozen_%0d", i), ctl(), C_FROZEN);
      step();
    end
    settle(); check("to_err_ctl", ctl(), C_OFF);
    check("to_err_flag", 32'(mem_timeout), 32'd1);
    check("to_err_cnt", 32'(stall_count), 32'd5);
    bus.dmem_ready = 1'b1;
    step(); step(); step();
    check("to_err_sticky_ctl", ctl(), C_OFF);
    check("to_err_sticky_flag", 32'(mem_timeout), 32'd1);
    check("to_err_cnt_grows", 32'(stall_count), 32'd8);
    idle_inputs();
    reset_pulse();
    settle(); check("to_rst_ctl", ctl(), C_IDLE);
    check("to_rst_flag", 32'(mem_timeout), 32'd0);

    // Saturation of the 4-bit stall counter
    bus.idex_memread = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 9)  check("sat_cnt_10", 32'(stall_count), 32'd10);
      if (i == 14) check("sat_cnt_15", 32'(stall_count), 32'd15);
    end
    check("sat_cnt_hold", 32'(stall_count), 32'd15);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
